// File: rtl/lwc_pkg.sv
// Shared constants and helpers for the SpoC-64 LWC output stage.
// Contents: opcodes, segment types, status words, header field positions,
// FSM state encoding and the tail-byte keep-mask function.
package lwc_pkg;

  localparam int unsigned LEN_FIELD_W = 16;

  // Instruction opcodes (cmd_data[31:28])
  localparam logic [3:0] OP_ENC    = 4'b0010;
  localparam logic [3:0] OP_DEC    = 4'b0011;
  localparam logic [3:0] OP_LDKEY  = 4'b0100;
  localparam logic [3:0] OP_ACTKEY = 4'b0111;

  // Segment header types
  localparam logic [3:0] SEG_PT  = 4'b0100;
  localparam logic [3:0] SEG_CT  = 4'b0101;
  localparam logic [3:0] SEG_TAG = 4'b1000;

  // Status words and tag header base (TAG, EOI=1, last=1)
  localparam logic [31:0] STATUS_SUCCESS = 32'hE000_0000;
  localparam logic [31:0] STATUS_FAILURE = 32'hF000_0000;
  localparam logic [31:0] TAG_HDR_BASE   = 32'h8300_0000;

  // Header field bit positions
  localparam int unsigned HDR_TYPE_MSB = 31;
  localparam int unsigned HDR_TYPE_LSB = 28;
  localparam int unsigned HDR_EOI_BIT  = 25;
  localparam int unsigned HDR_LAST_BIT = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_IN,
    ST_HDR_OUT,
    ST_DATA,
    ST_TAG_HDR,
    ST_TAG,
    ST_AUTH,
    ST_STATUS
  } state_t;

  // Keep mask for a big-endian word: bit 3 = byte 0 = bits [31:24]
  function automatic logic [3:0] byte_mask(input logic [LEN_FIELD_W-1:0] len);
    logic [3:0] m;
    m = 4'b0000;
    if (len >= LEN_FIELD_W'(4)) begin
      m = 4'b1111;
    end else begin
      case (len[1:0])
        2'd1:    m = 4'b1000;
        2'd2:    m = 4'b1100;
        2'd3:    m = 4'b1110;
        default: m = 4'b0000;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/lwc_postprocessor.sv
// LWC output stage: turns segment headers into output headers, passes
// PT/CT words through with tail masking, appends the tag on encrypt and
// closes each operation with a status word.
// Ports: clk/rst (async active-low); cmd_* header stream from the
// preprocessor; bdo_* data/tag stream from the core; msg_auth_* tag
// verdict on decrypt; do_* output stream (do_last marks the status word).
module lwc_postprocessor
  import lwc_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned TAG_WORDS = 2,
  parameter int unsigned LEN_W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  cmd_data,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] bdo,
  input  logic         bdo_valid,
  output logic         bdo_ready,
  input  logic [3:0]   bdo_valid_bytes,
  input  logic         end_of_block,
  input  logic         msg_auth,
  input  logic         msg_auth_valid,
  output logic         msg_auth_ready,
  output logic [W-1:0] do_data,
  output logic         do_valid,
  input  logic         do_ready,
  output logic         do_last
);

  localparam int unsigned TAG_CTR_W = $clog2(TAG_WORDS + 1);

  state_t               state;
  logic [W-1:0]         out_reg;
  logic                 do_valid_r;
  logic                 do_last_r;
  logic                 cmd_ready_r;
  logic                 msg_auth_ready_r;
  logic [LEN_W-1:0]     len_rem;
  logic [TAG_CTR_W-1:0] tag_ctr;
  logic                 dec_reg;
  logic                 last_seg;

  logic        pass_c;
  logic        cmd_xfer_c;
  logic        bdo_xfer_c;
  logic        out_xfer_c;
  logic        len_last_c;
  logic        seg_exit_c;
  logic [3:0]  keep_c;
  logic [31:0] keep_bits_c;
  logic [3:0]  seg_type_c;
  logic [31:0] hdr_c;
  state_t      seg_done_c;

  // The byte-valid mask from the core is advisory only
  logic unused_bits;
  assign unused_bits = ^bdo_valid_bytes;

  assign pass_c     = (state == ST_DATA) || (state == ST_TAG);
  assign cmd_xfer_c = cmd_valid & cmd_ready_r;
  assign bdo_xfer_c = pass_c & bdo_valid & do_ready;
  assign out_xfer_c = do_valid_r & do_ready;
  assign len_last_c = (len_rem <= LEN_W'(4));
  assign keep_c     = byte_mask(LEN_FIELD_W'(len_rem));
  assign keep_bits_c = {{8{keep_c[3]}}, {8{keep_c[2]}}, {8{keep_c[1]}}, {8{keep_c[0]}}};

  // A segment is finished when its header leaves with no payload or its last word leaves
  assign seg_exit_c = ((state == ST_HDR_OUT) && out_xfer_c && (len_rem == '0)) ||
                      ((state == ST_DATA) && bdo_xfer_c && len_last_c);

  // Where to go once a segment is complete
  always_comb begin
    seg_done_c = ST_HDR_IN;
    if (last_seg) seg_done_c = dec_reg ? ST_AUTH : ST_TAG_HDR;
  end

  // Output header: swap PT/CT by direction, keep EOI only on decrypt
  always_comb begin
    seg_type_c = cmd_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
    if (!dec_reg && (seg_type_c == SEG_PT))     seg_type_c = SEG_CT;
    else if (dec_reg && (seg_type_c == SEG_CT)) seg_type_c = SEG_PT;
    hdr_c = cmd_data;
    hdr_c[HDR_TYPE_MSB:HDR_TYPE_LSB] = seg_type_c;
    hdr_c[HDR_EOI_BIT] = dec_reg & cmd_data[HDR_EOI_BIT];
  end

  // Data and tag words flow straight through; everything else comes from out_reg
  assign do_valid       = pass_c ? bdo_valid : do_valid_r;
  assign bdo_ready      = pass_c & do_ready;
  assign do_data        = !pass_c ? out_reg :
                          (state == ST_DATA) ? (bdo & W'(keep_bits_c)) : bdo;
  assign do_last        = do_last_r;
  assign cmd_ready      = cmd_ready_r;
  assign msg_auth_ready = msg_auth_ready_r;

  // Control FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      out_reg          <= '0;
      do_valid_r       <= 1'b0;
      do_last_r        <= 1'b0;
      cmd_ready_r      <= 1'b0;
      msg_auth_ready_r <= 1'b0;
      len_rem          <= '0;
      tag_ctr          <= '0;
      dec_reg          <= 1'b0;
      last_seg         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready_r <= 1'b1;
          if (cmd_xfer_c) begin
            case (cmd_data[HDR_TYPE_MSB:HDR_TYPE_LSB])
              OP_ENC, OP_DEC: begin
                dec_reg <= cmd_data[HDR_TYPE_LSB];
                state   <= ST_HDR_IN;
              end
              OP_LDKEY, OP_ACTKEY: ;
              default: ;
            endcase
          end
        end
        ST_HDR_IN: begin
          if (cmd_xfer_c) begin
            len_rem     <= cmd_data[LEN_W-1:0];
            last_seg    <= cmd_data[HDR_LAST_BIT];
            out_reg     <= W'(hdr_c);
            do_valid_r  <= 1'b1;
            cmd_ready_r <= 1'b0;
            state       <= ST_HDR_OUT;
          end
        end
        ST_HDR_OUT: begin
          if (out_xfer_c) begin
            do_valid_r <= 1'b0;
            out_reg    <= '0;
            if (len_rem != '0) state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bdo_xfer_c) len_rem <= len_last_c ? '0 : len_rem - LEN_W'(4);
        end
        ST_TAG_HDR: begin
          if (out_xfer_c) begin
            do_valid_r <= 1'b0;
            out_reg    <= '0;
            tag_ctr    <= '0;
            state      <= ST_TAG;
          end
        end
        ST_TAG: begin
          if (bdo_xfer_c) begin
            tag_ctr <= tag_ctr + TAG_CTR_W'(1);
            if (tag_ctr == TAG_CTR_W'(TAG_WORDS - 1)) begin
              out_reg    <= W'(STATUS_SUCCESS);
              do_valid_r <= 1'b1;
              do_last_r  <= 1'b1;
              state      <= ST_STATUS;
            end
          end
        end
        ST_AUTH: begin
          msg_auth_ready_r <= 1'b1;
          if (msg_auth_valid && msg_auth_ready_r) begin
            out_reg          <= msg_auth ? W'(STATUS_SUCCESS) : W'(STATUS_FAILURE);
            do_valid_r       <= 1'b1;
            do_last_r        <= 1'b1;
            msg_auth_ready_r <= 1'b0;
            state            <= ST_STATUS;
          end
        end
        ST_STATUS: begin
          if (out_xfer_c) begin
            out_reg     <= '0;
            do_valid_r  <= 1'b0;
            do_last_r   <= 1'b0;
            cmd_ready_r <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Segment completion overrides the per-state updates above
      if (seg_exit_c) begin
        state            <= seg_done_c;
        cmd_ready_r      <= (seg_done_c == ST_HDR_IN);
        msg_auth_ready_r <= (seg_done_c == ST_AUTH);
        do_valid_r       <= (seg_done_c == ST_TAG_HDR);
        out_reg          <= (seg_done_c == ST_TAG_HDR) ?
                            W'(TAG_HDR_BASE | 32'(TAG_WORDS * 4)) : '0;
      end
    end
  end

`ifndef SYNTHESIS
  // Sticky flag: core's end_of_block disagrees with the length count
  logic eob_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) eob_err <= 1'b0;
    else if ((state == ST_DATA) && bdo_xfer_c && (end_of_block != len_last_c)) eob_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!eob_err) else $error("end_of_block inconsistent with segment length");
  end
`endif

endmodule

// File: tb/tb_lwc_postprocessor.sv
// Scoreboard bench for lwc_postprocessor: directed operations push their
// expected output words into a queue; a monitor pops and compares on every
// do_* transfer and checks that stalled outputs hold steady.
module tb_lwc_postprocessor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] bdo;
  logic        bdo_valid;
  logic        bdo_ready;
  logic [3:0]  bdo_valid_bytes;
  logic        end_of_block;
  logic        msg_auth;
  logic        msg_auth_valid;
  logic        msg_auth_ready;
  logic [31:0] do_data;
  logic        do_valid;
  logic        do_ready;
  logic        do_last;

  always #5 clk = ~clk;

  lwc_postprocessor dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_data        (cmd_data),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .bdo             (bdo),
    .bdo_valid       (bdo_valid),
    .bdo_ready       (bdo_ready),
    .bdo_valid_bytes (bdo_valid_bytes),
    .end_of_block    (end_of_block),
    .msg_auth        (msg_auth),
    .msg_auth_valid  (msg_auth_valid),
    .msg_auth_ready  (msg_auth_ready),
    .do_data         (do_data),
    .do_valid        (do_valid),
    .do_ready        (do_ready),
    .do_last         (do_last)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bdo_rdy_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake timed out", name);
  endfunction

  task automatic push(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each output transfer against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold_valid", 32'(do_valid), 32'd1);
        chk("stall_hold_data", do_data, stall_data);
      end
      if (bdo_ready) begin
        bdo_rdy_cnt++;
        chk("bdo_ready_mirror", 32'(do_ready), 32'd1);
      end
      if (do_valid && do_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%08h, expected no output", do_data);
        end else begin
          e = exp_q.pop_front();
          chk("do_data", do_data, e.data);
          chk("do_last", 32'(do_last), 32'(e.last));
        end
      end
      stall_prev = do_valid && !do_ready;
      stall_data = do_data;
    end
  end

  // Driver tasks: enter at posedge+1, return at posedge+1 after the transfer
  task automatic send_cmd(input logic [31:0] w);
    int n = 0;
    cmd_data  = w;
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    if (!cmd_ready) timeout("cmd_handshake");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_bdo(input logic [31:0] w, input logic eob);
    int n = 0;
    bdo          = w;
    end_of_block = eob;
    bdo_valid    = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bdo_ready && n < 100);
    if (!bdo_ready) timeout("bdo_handshake");
    @(posedge clk);
    #1;
    bdo_valid    = 1'b0;
    end_of_block = 1'b0;
  endtask

  task automatic send_auth(input logic v);
    int n = 0;
    msg_auth       = v;
    msg_auth_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!msg_auth_ready && n < 100);
    if (!msg_auth_ready) timeout("auth_handshake");
    @(posedge clk);
    #1;
    msg_auth_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout("drain");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},      32'(cmd_ready),      32'd0);
    chk({tag, "_bdo_ready"},      32'(bdo_ready),      32'd0);
    chk({tag, "_msg_auth_ready"}, 32'(msg_auth_ready), 32'd0);
    chk({tag, "_do_valid"},       32'(do_valid),       32'd0);
    chk({tag, "_do_last"},        32'(do_last),        32'd0);
    chk({tag, "_do_data"},        do_data,             32'd0);
  endtask

  // ENC, PT len=5 last=1, tail word masked to one byte
  task automatic run_enc_len5();
    push(32'h5100_0005, 1'b0);
    push(32'hAABB_CCDD, 1'b0);
    push(32'h1100_0000, 1'b0);
    push(32'h8300_0008, 1'b0);
    push(32'h0102_0304, 1'b0);
    push(32'h0506_0708, 1'b0);
    push(32'hE000_0000, 1'b1);
    send_cmd(32'h2000_0000);
    send_cmd(32'h4100_0005);
    send_bdo(32'hAABB_CCDD, 1'b0);
    send_bdo(32'h1122_3344, 1'b1);
    send_bdo(32'h0102_0304, 1'b0);
    send_bdo(32'h0506_0708, 1'b1);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_data        = '0;
    cmd_valid       = 1'b0;
    bdo             = '0;
    bdo_valid       = 1'b0;
    bdo_valid_bytes = 4'hF;
    end_of_block    = 1'b0;
    msg_auth        = 1'b0;
    msg_auth_valid  = 1'b0;
    do_ready        = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Encrypt with a short tail word
    run_enc_len5();

    // Decrypt, empty CT segment, tag mismatch
    bdo_rdy_cnt = 0;
    push(32'h4300_0000, 1'b0);
    push(32'hF000_0000, 1'b1);
    send_cmd(32'h3000_0000);
    send_cmd(32'h5300_0000);
    send_auth(1'b0);
    wait_drain();
    chk("dec_no_bdo_ready", 32'(bdo_rdy_cnt), 32'd0);

    // Encrypt, two PT segments of four bytes
    push(32'h5000_0004, 1'b0);
    push(32'h0123_4567, 1'b0);
    push(32'h5100_0004, 1'b0);
    push(32'h89AB_CDEF, 1'b0);
    push(32'h8300_0008, 1'b0);
    push(32'hA1A2_A3A4, 1'b0);
    push(32'hB1B2_B3B4, 1'b0);
    push(32'hE000_0000, 1'b1);
    send_cmd(32'h2000_0000);
    send_cmd(32'h4000_0004);
    send_bdo(32'h0123_4567, 1'b1);
    send_cmd(32'h4100_0004);
    send_bdo(32'h89AB_CDEF, 1'b1);
    send_bdo(32'hA1A2_A3A4, 1'b0);
    send_bdo(32'hB1B2_B3B4, 1'b1);
    wait_drain();

    // Encrypt with do_ready pattern 1,0,0,1 across the data words
    push(32'h5100_0008, 1'b0);
    push(32'hDEAD_BEEF, 1'b0);
    push(32'hCAFE_F00D, 1'b0);
    push(32'h8300_0008, 1'b0);
    push(32'h0A0B_0C0D, 1'b0);
    push(32'h1020_3040, 1'b0);
    push(32'hE000_0000, 1'b1);
    send_cmd(32'h2000_0000);
    send_cmd(32'h4100_0008);
    @(posedge clk);
    #1;
    bdo          = 32'hDEAD_BEEF;
    end_of_block = 1'b0;
    bdo_valid    = 1'b1;
    do_ready     = 1'b1;
    @(posedge clk);
    #1;
    bdo          = 32'hCAFE_F00D;
    end_of_block = 1'b1;
    do_ready     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_bdo_ready", 32'(bdo_ready), 32'd0);
      chk("stall_do_data", do_data, 32'hCAFE_F00D);
      @(posedge clk);
      #1;
    end
    do_ready = 1'b1;
    @(posedge clk);
    #1;
    bdo_valid    = 1'b0;
    end_of_block = 1'b0;
    send_bdo(32'h0A0B_0C0D, 1'b0);
    send_bdo(32'h1020_3040, 1'b1);
    wait_drain();

    // Key instructions produce nothing; then decrypt with a good tag
    push(32'h4100_0000, 1'b0);
    push(32'hE000_0000, 1'b1);
    send_cmd(32'h4000_0000);
    send_cmd(32'h7000_0000);
    send_cmd(32'h3000_0000);
    send_cmd(32'h5100_0000);
    send_auth(1'b1);
    wait_drain();

    // Reset in the middle of a data segment
    push(32'h5100_0008, 1'b0);
    send_cmd(32'h2000_0000);
    send_cmd(32'h4100_0008);
    @(posedge clk);
    #1;
    bdo       = 32'h1234_5678;
    bdo_valid = 1'b1;
    do_ready  = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
    bdo_valid = 1'b0;
    do_ready  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_enc_len5();

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
